dds_rd_cmd: RTL and testbench
=============================

Name: dds_rd_cmd

Overview:
- Register-read initiator for the DDS serial port; the read-direction counterpart of the command writer.
- On `start`, sends a SYNCIO pulse, then an 8-bit read instruction on SDIO, then clocks in NBYTES data bytes from SDO.
- Returns the data right-aligned on `dout` with a one-cycle `done` pulse.
- Sits beside the writer on the same DDS SPI pins; an external arbiter muxes pin ownership using `busy`.

Parameters:
- CLK_DIV, 2: SCLK half-period in `clk` cycles (H); legal range 1..255.
- MAX_BYTES, 8: maximum data bytes per read; sets the `dout` width to 8*MAX_BYTES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- addr  in  8  register address; instruction = {1'b1, addr[6:0]}; addr[7] ignored
- nbytes  in  4  data bytes to read; 0 is treated as 1; values above MAX_BYTES clamp to MAX_BYTES; latched on start
- dout  out  8*MAX_BYTES  read data; last byte received in [7:0]; unused upper bits 0
- done  out  1  one-cycle pulse when `dout` is valid
- busy  out  1  high from the cycle after start acceptance until the done cycle inclusive
- SYNCIO  out  1  DDS serial-port sync pulse
- SCLK  out  1  serial clock, idle low
- SDIO  out  1  serial data to DDS
- CS  out  1  chip select, active low, idle high
- SDO  in  1  serial data from DDS

Behaviour:
- Reset (sync, wins over everything, including mid-transfer): state IDLE, CS=1, SCLK=0, SDIO=0, SYNCIO=0, done=0, busy=0, dout=0.
- Timing terms: H = CLK_DIV; B = 8*(1+nbytes_eff) total bits; k = the cycle in which `start` is accepted in IDLE.
- IDLE: all pins at their reset values; `dout` holds its last value. On start, latch the instruction and nbytes_eff, clear the shift register, go to SYNC.
- SYNC: cycles k+1..k+2. SYNCIO=1, CS=1, busy=1.
- SHIFT: CS=0 from cycle k+3.
  - Each bit = H cycles with SCLK low, then H cycles with SCLK high.
  - SDIO changes only on the first cycle of each low phase.
  - SDO is sampled in the cycle SCLK rises.
  - Bits 0..7 transmit the instruction MSB-first; SDO samples during these bits are discarded.
  - Bits 8..B-1 drive SDIO=0 and shift SDO samples into `dout`, MSB-first per byte, bytes in arrival order.
- HOLD: H cycles, SCLK=0, CS=0.
- DONE: at cycle k+3+2*H*B+H, CS=1, done=1, busy=1, `dout` updated. Next cycle: IDLE, done=0, busy=0.
- `start` while busy is ignored, with no queueing. `start` in the DONE cycle is ignored; `start` in the first IDLE cycle is accepted.
- `dout` updates only in the DONE cycle; partial data is never visible.
- SCLK never toggles while CS=1. No glitch on CS between bytes: CS stays low through all bytes of one read.
- Bit and half-period counters wrap only at their terminal counts and cannot overflow, because B ≤ 8*(1+MAX_BYTES).

Optional Feature:
- Macro: LSB_FIRST_EN.
- Defined: instruction bits and each data byte are shifted LSB-first on both SDIO and SDO. Byte order in `dout` is unchanged (last byte in [7:0]).
- Undefined: MSB-first as above.
- Timing is identical in both builds.

Decomposition:
- Package dds_spi_pkg holds:
  - state enum {IDLE, SYNC, SHIFT, HOLD, DONE};
  - READ_FLAG = 1'b1;
  - INSTR_W = 8;
  - SYNC_CYCLES = 2;
  - the nbytes clamp function.
- Sub-module spi_clk_div (natural split): H-cycle counter producing `fall_tick` and `rise_tick` strobes, enabled only in SHIFT. The FSM and shift registers stay in dds_rd_cmd.

Test Plan:
- Basic read: H=2, addr=8'h07, nbytes=4, SDO model returns 32'hDEADBEEF → SDIO instruction 8'h87; done at k+165; dout[31:0]=32'hDEADBEEF, upper bits 0; exactly 40 SCLK rising edges.
- Clamping: nbytes=0 → 16 SCLK edges, dout=8'hA5 for byte A5. nbytes=15 with MAX_BYTES=8 → 72 edges.
- Start while busy: second start at k+20 with addr=8'h01 → ignored; instruction stays 8'h87; a single done pulse.
- Reset mid-transfer: assert rst at k+50 → the next cycle shows CS=1, SCLK=0, busy=0, dout=0. A later start runs a clean full transfer.
- Back-to-back: start in the first IDLE cycle after done → accepted; SYNCIO pulses again for 2 cycles; CS high for at least 3 cycles between transfers.
- LSB_FIRST_EN build: addr=8'h07 → SDIO bit sequence 1,1,1,0,0,0,0,1; SDO byte 8'h01 sent LSB-first → dout=8'h01.

Source files
------------

// File: rtl/dds_spi_pkg.sv
// rtl/dds_spi_pkg.sv - shared types, constants and helpers for the DDS serial-port blocks
package dds_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  localparam logic READ_FLAG   = 1'b1;
  localparam int   INSTR_W     = 8;
  localparam int   SYNC_CYCLES = 2;

  // Zero requests one byte; anything above the configured maximum is clamped.
  function automatic logic [3:0] clamp_nbytes(input logic [3:0] n, input logic [3:0] max_b);
    logic [3:0] r;
    r = (n == 4'd0) ? 4'd1 : n;
    if (r > max_b) r = max_b;
    return r;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - SCLK half-period divider with rise/fall strobes, active only while enabled
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam logic [7:0] HMAX = 8'(CLK_DIV - 1);

  logic [7:0] hcnt;

  // Count H cycles per phase; held at low phase, count 0 whenever disabled.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      hcnt <= '0;
      sclk <= 1'b0;
    end else if (hcnt == HMAX) begin
      hcnt <= '0;
      sclk <= ~sclk;
    end else begin
      hcnt <= hcnt + 8'd1;
    end
  end

  // rise_tick marks the first high cycle (SDO sample point), fall_tick the last one.
  assign rise_tick = en && sclk && (hcnt == 8'd0);
  assign fall_tick = en && sclk && (hcnt == HMAX);

endmodule

// File: rtl/dds_rd_cmd.sv
// rtl/dds_rd_cmd.sv - DDS serial-port register read initiator; LSB_FIRST_EN selects LSB-first bit order
module dds_rd_cmd
  import dds_spi_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int MAX_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             addr,
  input  logic [3:0]             nbytes,
  output logic [8*MAX_BYTES-1:0] dout,
  output logic                   done,
  output logic                   busy,
  output logic                   SYNCIO,
  output logic                   SCLK,
  output logic                   SDIO,
  output logic                   CS,
  input  logic                   SDO
);

  localparam int         DW        = 8 * MAX_BYTES;
  localparam int         BMAX      = 8 * (1 + MAX_BYTES);
  localparam int         BCW       = $clog2(BMAX);
  localparam logic [7:0] HMAX      = 8'(CLK_DIV - 1);
  localparam logic [7:0] SYNC_LAST = 8'(SYNC_CYCLES - 1);
  localparam logic [3:0] MAXB      = 4'(MAX_BYTES);

  state_t          state;
  logic [7:0]      instr_sr;
  logic [BCW-1:0]  bit_cnt;
  logic [BCW-1:0]  last_bit;
  logic [7:0]      cyc_cnt;
  logic [7:0]      byte_sr;
  logic [DW-1:0]   data_sr;

  logic [3:0]      nb_eff;
  logic [7:0]      byte_next;
  logic            instr_bit;
  logic [7:0]      instr_shifted;
  logic            is_data;
  logic            byte_end;
  logic            rise_tick;
  logic            fall_tick;
  logic            sclk_int;
  logic            unused_addr_msb;

  assign unused_addr_msb = addr[7];
  assign nb_eff          = clamp_nbytes(nbytes, MAXB);
  assign is_data         = (bit_cnt >= BCW'(INSTR_W));
  assign byte_end        = (bit_cnt[2:0] == 3'd7);
  assign SCLK            = sclk_int;

`ifdef LSB_FIRST_EN
  assign byte_next     = {SDO, byte_sr[7:1]};
  assign instr_bit     = instr_sr[0];
  assign instr_shifted = {1'b0, instr_sr[7:1]};
`else
  assign byte_next     = {byte_sr[6:0], SDO};
  assign instr_bit     = instr_sr[7];
  assign instr_shifted = {instr_sr[6:0], 1'b0};
`endif

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk       (clk),
    .rst       (rst),
    .en        (state == SHIFT),
    .sclk      (sclk_int),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Transfer sequencer: sync pulse, instruction out, data in, hold, then publish dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      CS       <= 1'b1;
      SDIO     <= 1'b0;
      SYNCIO   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      dout     <= '0;
      instr_sr <= '0;
      bit_cnt  <= '0;
      last_bit <= '0;
      cyc_cnt  <= '0;
      byte_sr  <= '0;
      data_sr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            instr_sr <= {READ_FLAG, addr[6:0]};
            last_bit <= BCW'(8 * (int'(nb_eff) + 1) - 1);
            data_sr  <= '0;
            byte_sr  <= '0;
            bit_cnt  <= '0;
            cyc_cnt  <= '0;
            SYNCIO   <= 1'b1;
            busy     <= 1'b1;
            state    <= SYNC;
          end
        end
        SYNC: begin
          if (cyc_cnt == SYNC_LAST) begin
            SYNCIO   <= 1'b0;
            CS       <= 1'b0;
            SDIO     <= instr_bit;
            instr_sr <= instr_shifted;
            cyc_cnt  <= '0;
            state    <= SHIFT;
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
        SHIFT: begin
          // Instruction-phase samples are dropped; data bytes are committed whole.
          if (rise_tick && is_data) begin
            byte_sr <= byte_next;
            if (byte_end) data_sr <= DW'({data_sr, byte_next});
          end
          if (fall_tick) begin
            if (bit_cnt == last_bit) begin
              SDIO    <= 1'b0;
              cyc_cnt <= '0;
              state   <= HOLD;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              SDIO     <= instr_bit;
              instr_sr <= instr_shifted;
            end
          end
        end
        HOLD: begin
          if (cyc_cnt == HMAX) begin
            CS    <= 1'b1;
            done  <= 1'b1;
            dout  <= data_sr;
            state <= DONE;
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_rd_cmd.sv
// tb/tb_dds_rd_cmd.sv - directed self-checking bench for dds_rd_cmd
module tb_dds_rd_cmd;

`ifdef LSB_FIRST_EN
  localparam bit         LSB     = 1'b1;
  localparam logic [7:0] EXP_I87 = 8'hE1;
`else
  localparam bit         LSB     = 1'b0;
  localparam logic [7:0] EXP_I87 = 8'h87;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  addr;
  logic [3:0]  nbytes;
  logic [63:0] dout;
  logic        done, busy, SYNCIO, SCLK, SDIO, CS, SDO;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fall_cnt = 0, rise_cnt = 0, done_cnt = 0, sync_cnt = 0, cs_rise = 0, viol = 0;
  int cs_run = 0, last_run = 0;
  int sdo_base = 0;
  logic [127:0] sdo_stream = '1;
  logic [127:0] hist = '0;
  logic [6:0]   sidx;

  dds_rd_cmd #(.CLK_DIV(2), .MAX_BYTES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .nbytes(nbytes),
    .dout(dout), .done(done), .busy(busy), .SYNCIO(SYNCIO), .SCLK(SCLK),
    .SDIO(SDIO), .CS(CS), .SDO(SDO)
  );

  always #5 clk = ~clk;

  assign sidx = 7'(fall_cnt - sdo_base);
  assign SDO  = sdo_stream[sidx];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;
  always @(negedge clk) if (SYNCIO) sync_cnt <= sync_cnt + 1;
  always @(negedge clk) begin
    if (CS) cs_run <= cs_run + 1;
    else if (cs_run != 0) begin
      last_run <= cs_run;
      cs_run   <= 0;
    end
  end
  always @(negedge SCLK) fall_cnt <= fall_cnt + 1;
  always @(posedge SCLK) begin
    rise_cnt <= rise_cnt + 1;
    hist     <= {hist[126:0], SDIO};
    if (CS) viol <= viol + 1;
  end
  always @(posedge CS) cs_rise <= cs_rise + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One read; returns latency from acceptance cycle to done, data, SCLK rises and sent instruction.
  task automatic do_read(input logic [7:0] a, input logic [3:0] nb, input int nbe,
                         input logic [63:0] data, input int inj,
                         output int lat, output logic [63:0] d, output int rises,
                         output logic [7:0] instr);
    logic [127:0] s;
    logic [7:0]   b;
    int k, r0, nbits;
    s = '1;
    for (int n = 0; n < nbe; n++) begin
      b = data[8*(nbe-1-n) +: 8];
      for (int t = 0; t < 8; t++) s[8 + 8*n + t] = LSB ? b[t] : b[7-t];
    end
    nbits = 8 * (1 + nbe);
    lat = -1;
    @(posedge clk); #1;
    sdo_stream = s;
    sdo_base   = fall_cnt;
    r0         = rise_cnt;
    addr = a; nbytes = nb; start = 1'b1; k = cyc;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (inj != 0 && cyc - k == inj) begin
        start = 1'b1;
        addr  = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        lat = cyc - k;
        break;
      end
    end
    start = 1'b0;
    d     = dout;
    rises = rise_cnt - r0;
    instr = hist[nbits-1 -: 8];
    chk("busy_in_done", 64'(busy), 64'd1);
  endtask

  int          lat, rises, s0, d0, c0, k;
  logic [63:0] d;
  logic [7:0]  instr;

  initial begin
    rst = 1'b1; start = 1'b0; addr = 8'h00; nbytes = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", 64'(CS), 64'd1);
    chk("rst_sclk", 64'(SCLK), 64'd0);
    chk("rst_sdio", 64'(SDIO), 64'd0);
    chk("rst_syncio", 64'(SYNCIO), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dout", dout, 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic read of four bytes
    s0 = sync_cnt; d0 = done_cnt; c0 = cs_rise;
    do_read(8'h07, 4'd4, 4, 64'hDEADBEEF, 0, lat, d, rises, instr);
    chk("basic_lat", 64'(lat), 64'd165);
    chk("basic_dout", d, 64'h00000000DEADBEEF);
    chk("basic_rises", 64'(rises), 64'd40);
    chk("basic_instr", 64'(instr), 64'(EXP_I87));
    @(negedge clk);
    chk("basic_done_clr", 64'(done), 64'd0);
    chk("basic_busy_clr", 64'(busy), 64'd0);
    chk("basic_sync_len", 64'(sync_cnt - s0), 64'd2);
    chk("basic_cs_once", 64'(cs_rise - c0), 64'd1);
    chk("basic_done_once", 64'(done_cnt - d0), 64'd1);

    // nbytes=0 behaves as one byte
    do_read(8'h07, 4'd0, 1, 64'hA5, 0, lat, d, rises, instr);
    chk("nb0_lat", 64'(lat), 64'd69);
    chk("nb0_rises", 64'(rises), 64'd16);
    chk("nb0_dout", d, 64'hA5);
    @(negedge clk);

    // nbytes=15 clamps to eight bytes
    do_read(8'h2A, 4'd15, 8, 64'h0123456789ABCDEF, 0, lat, d, rises, instr);
    chk("nb15_lat", 64'(lat), 64'd293);
    chk("nb15_rises", 64'(rises), 64'd72);
    chk("nb15_dout", d, 64'h0123456789ABCDEF);
    @(negedge clk);

    // Start while busy is ignored
    d0 = done_cnt;
    do_read(8'h07, 4'd1, 1, 64'h3C, 20, lat, d, rises, instr);
    chk("busy_lat", 64'(lat), 64'd69);
    chk("busy_instr", 64'(instr), 64'(EXP_I87));
    chk("busy_dout", d, 64'h3C);
    repeat (5) @(negedge clk);
    chk("busy_done_once", 64'(done_cnt - d0), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);

    // Reset mid-transfer
    @(posedge clk); #1;
    addr = 8'h07; nbytes = 4'd4; start = 1'b1; k = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && cyc - k < 50; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_cs", 64'(CS), 64'd1);
    chk("mid_rst_sclk", 64'(SCLK), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_dout", dout, 64'd0);
    repeat (3) @(negedge clk);

    // Clean transfer after reset, then back-to-back
    do_read(8'h07, 4'd2, 2, 64'h1234, 0, lat, d, rises, instr);
    chk("post_rst_lat", 64'(lat), 64'd101);
    chk("post_rst_dout", d, 64'h1234);
    chk("post_rst_instr", 64'(instr), 64'(EXP_I87));
    s0 = sync_cnt;
    do_read(8'h07, 4'd1, 1, 64'h01, 0, lat, d, rises, instr);
    chk("b2b_lat", 64'(lat), 64'd69);
    chk("b2b_dout", d, 64'h01);
    chk("b2b_sync_len", 64'(sync_cnt - s0), 64'd2);
    chk("b2b_cs_gap", 64'(last_run), 64'd4);
    chk("b2b_instr", 64'(instr), 64'(EXP_I87));
    chk("sclk_under_cs", 64'(viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
